// File: rtl/sn_to_bn_counter.sv
// sn_to_bn_counter
//   Stochastic-to-binary decoder. Counts the ones on each of N_LANE parallel
//   unipolar bit streams over a frame and publishes the per-lane count as a
//   W-bit binary value. A frame opens on the first cycle with i_isgen high.
//   It closes on the first cycle with i_isgen low, or automatically once
//   STREAM_LEN valid bits have been collected. In the automatic case a new
//   frame opens in the same cycle if i_isgen is still high.
//
// Ports
//   i_clk_sn2bn    in   1             clock, rising edge
//   i_rst_n_sn2bn  in   1             asynchronous active-low reset
//   i_isgen        in   1             frame-valid strobe
//   i_sn_bit       in   N_LANE        one stream bit per lane
//   o_x_bn         out  N_LANE x W    recovered value per lane (registered, held)
//   o_valid        out  1             one-cycle pulse when o_x_bn updates
//   o_busy         out  1             high while a frame is being accumulated
module sn_to_bn_counter #(
  parameter int N_LANE     = 4,
  parameter int W          = 4,
  parameter int STREAM_LEN = 16
) (
  input  logic                       i_clk_sn2bn,
  input  logic                       i_rst_n_sn2bn,
  input  logic                       i_isgen,
  input  logic [N_LANE-1:0]          i_sn_bit,
  output logic [N_LANE-1:0][W-1:0]   o_x_bn,
  output logic                       o_valid,
  output logic                       o_busy
);

  // The length counter must be able to hold STREAM_LEN itself.
  localparam int LEN_W = $clog2(STREAM_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(STREAM_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [N_LANE-1:0][W-1:0]  r_cnt;
  logic [N_LANE-1:0][W-1:0]  r_x_bn;
  logic [N_LANE-1:0][W-1:0]  w_sat_sum;
  logic [LEN_W-1:0]          r_len;
  logic                      r_valid;
  logic                      w_close;   // publish r_cnt this cycle
  logic                      w_start;   // load first bit of a new frame
  logic                      w_inc;     // accumulate into the open frame

  // Per-lane saturating increment: a full frame of ones must read 2^W-1,
  // not wrap to zero.
  genvar gi;
  generate
    for (gi = 0; gi < N_LANE; gi++) begin : g_lane
      assign w_sat_sum[gi] = (&r_cnt[gi]) ? r_cnt[gi]
                                          : r_cnt[gi] + W'(i_sn_bit[gi]);
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_close      = 1'b0;
    w_start      = 1'b0;
    w_inc        = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_isgen) begin
          w_start      = 1'b1;
          w_state_next = ACC;
        end
      end
      ACC: begin
        if (!i_isgen) begin
          // Early end: the bit on this cycle is not part of the frame.
          w_close      = 1'b1;
          w_state_next = IDLE;
        end else if (r_len >= LEN_MAX) begin
          // Frame is full: close it and open the next one with this bit.
          w_close      = 1'b1;
          w_start      = 1'b1;
        end else begin
          w_inc        = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
    if (!i_rst_n_sn2bn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_x_bn  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_close;
      if (w_close) begin
        r_x_bn <= r_cnt;
      end
      if (w_start) begin
        for (int k = 0; k < N_LANE; k++) begin
          r_cnt[k] <= W'(i_sn_bit[k]);
        end
        r_len <= LEN_ONE;
      end else if (w_inc) begin
        r_cnt <= w_sat_sum;
        r_len <= r_len + LEN_ONE;
      end
    end
  end

  assign o_x_bn  = r_x_bn;
  assign o_valid = r_valid;
  assign o_busy  = (r_state == ACC);

endmodule
